// File: rtl/lsu_wb.sv
// lsu_wb: byte/half/word load-store unit bridging the execute stage to a pipelined Wishbone bus.
// Define LSU_WB_TIMEOUT_EN to add a bus-cycle timeout fault after TIMEOUT_CYCLES cycles of cyc.
module lsu_wb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_width,
    input  logic        i_signed,
    output logic [31:0] o_rdata,
    output logic        o_completed,
    output logic        o_busy,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic        i_wb_stl,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data
);

    // IDLE: accept | REQ: stb out | WAIT_ACK: cyc held for ack/err | DONE: completion pulse
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_we, r_signed, r_fault;
    logic [1:0]  r_width, r_lane, r_cause;
    logic [31:0] r_wb_addr, r_wb_data, r_rdata;
    logic [3:0]  r_wb_sel;

    logic        w_accept, w_bad_width, w_misalign, w_chk_fault;
    logic        w_cyc, w_take, w_ack, w_err, w_tmo;
    logic [3:0]  w_sel;
    logic [31:0] w_data, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept    = (r_state == S_IDLE) && i_enable;
    assign w_bad_width = (i_width == 2'b00);
    assign w_misalign  = ((i_width == 2'b10) && i_addr[0]) ||
                         ((i_width == 2'b11) && (i_addr[1:0] != 2'b00));
    assign w_chk_fault = w_bad_width || w_misalign;

    assign w_cyc  = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
    // ack/err only count once the strobe has actually been accepted
    assign w_take = ((r_state == S_REQ) && !i_wb_stl) || (r_state == S_WAIT_ACK);
    assign w_err  = w_take && i_wb_err;
    assign w_ack  = w_take && i_wb_ack && !i_wb_err;

`ifdef LSU_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (w_cyc) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    assign w_tmo = w_cyc && !w_ack && !w_err && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_sel  = 4'b0000;
        w_data = i_wdata;
        case (i_width)
            2'b01: begin
                w_sel  = 4'b0001 << i_addr[1:0];
                w_data = {4{i_wdata[7:0]}};
            end
            2'b10: begin
                w_sel  = i_addr[1] ? 4'b1100 : 4'b0011;
                w_data = {2{i_wdata[15:0]}};
            end
            2'b11:   w_sel = 4'b1111;
            default: w_sel = 4'b0000;
        endcase
    end

    assign w_byte = i_wb_data[{r_lane, 3'b000} +: 8];
    assign w_half = i_wb_data[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = i_wb_data;
        case (r_width)
            2'b01:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b10:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
            default: w_ext = i_wb_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = w_chk_fault ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack || w_err || w_tmo) begin
                    w_state_nxt = S_DONE;
                end else if (!i_wb_stl) begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (w_ack || w_err || w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we      <= 1'b0;
            r_signed  <= 1'b0;
            r_width   <= 2'b00;
            r_lane    <= 2'b00;
            r_wb_addr <= '0;
            r_wb_sel  <= '0;
            r_wb_data <= '0;
            r_rdata   <= '0;
            r_fault   <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_we      <= i_we;
                r_signed  <= i_signed;
                r_width   <= i_width;
                r_lane    <= i_addr[1:0];
                r_wb_addr <= {i_addr[31:2], 2'b00};
                r_wb_sel  <= w_sel;
                r_wb_data <= w_data;
                r_fault   <= w_chk_fault;
                if (w_chk_fault) begin
                    r_cause <= w_bad_width ? 2'b00 : 2'b01;
                end
            end
            if (w_err) begin
                r_fault <= 1'b1;
                r_cause <= 2'b10;
            end else if (w_ack && !r_we) begin
                r_rdata <= w_ext;
            end
            if (w_tmo) begin
                r_fault <= 1'b1;
                r_cause <= 2'b11;
            end
        end
    end

    assign o_rdata       = r_rdata;
    assign o_completed   = (r_state == S_DONE);
    assign o_busy        = w_cyc;
    assign o_fault       = r_fault;
    assign o_fault_cause = r_cause;
    assign o_wb_addr     = r_wb_addr;
    assign o_wb_data     = r_wb_data;
    assign o_wb_sel      = r_wb_sel;
    assign o_wb_we       = r_we;
    assign o_wb_cyc      = w_cyc;
    assign o_wb_stb      = (r_state == S_REQ);

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: scoreboard bench for lsu_wb with a programmable stall/wait/err Wishbone slave.
// Build with LSU_WB_TIMEOUT_EN to exercise the timeout path instead of the indefinite wait.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable, i_we, i_signed;
    logic [31:0] i_addr, i_wdata;
    logic [1:0]  i_width;
    logic [31:0] o_rdata, o_wb_addr, o_wb_data;
    logic        o_completed, o_busy, o_fault, o_wb_we, o_wb_cyc, o_wb_stb;
    logic [1:0]  o_fault_cause;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stl, i_wb_err;
    logic [31:0] i_wb_data;

    localparam int TO = 8;

    always #5 clk = ~clk;

    lsu_wb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .i_enable(i_enable), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_width(i_width), .i_signed(i_signed),
        .o_rdata(o_rdata), .o_completed(o_completed), .o_busy(o_busy),
        .o_fault(o_fault), .o_fault_cause(o_fault_cause),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_ack(i_wb_ack), .i_wb_stl(i_wb_stl), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
        int          lat;
        int          stb_n;
        int          t_en;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    int          cycle_n = 0;
    int          stb_cnt = 0;
    logic [31:0] m_rdata = '0;

    int          sl_stall = 0, sl_wait = 0, sl_cnt = 0, sl_wcnt = 0;
    logic        sl_err = 1'b0, sl_ack_too = 1'b0, sl_hang = 1'b0;
    logic [31:0] sl_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cycle_n);
        end
    endtask

    always @(posedge clk) cycle_n <= cycle_n + 1;

    // Slave: stall sl_stall strobe cycles, then answer sl_wait cycles after acceptance.
    // Outside a bus cycle it drives random ack/err that the DUT must ignore.
    always @(negedge clk) begin
        i_wb_stl  = 1'b0;
        i_wb_ack  = 1'b0;
        i_wb_err  = 1'b0;
        i_wb_data = $urandom;
        if (!o_wb_cyc) begin
            i_wb_ack = 1'($urandom_range(0, 1));
            i_wb_err = 1'($urandom_range(0, 1));
        end else if (o_wb_stb && (sl_cnt < sl_stall)) begin
            i_wb_stl = 1'b1;
            sl_cnt++;
        end else begin
            if (!o_wb_stb) sl_wcnt++;
            if ((sl_wcnt >= sl_wait) && !sl_hang) begin
                i_wb_err  = sl_err;
                i_wb_ack  = !sl_err || sl_ack_too;
                i_wb_data = sl_data;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            stb_cnt = 0;
        end else begin
            if (o_wb_stb) begin
                stb_cnt++;
                chk("stb_owner", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    chk("wb_addr", o_wb_addr, sb_q[0].addr);
                    chk("wb_sel", {28'h0, o_wb_sel}, {28'h0, sb_q[0].sel});
                    chk("wb_we", {31'h0, o_wb_we}, {31'h0, sb_q[0].we});
                    if (sb_q[0].we) chk("wb_data", o_wb_data, sb_q[0].data);
                    chk("busy_req", {31'h0, o_busy}, 32'h1);
                end
            end
            if (o_completed) begin
                chk("cmp_owner", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    chk("rdata", o_rdata, mon_e.rdata);
                    chk("fault", {31'h0, o_fault}, {31'h0, mon_e.fault});
                    if (mon_e.fault) chk("cause", {30'h0, o_fault_cause}, {30'h0, mon_e.cause});
                    chk("latency", cycle_n - mon_e.t_en, mon_e.lat);
                    chk("stb_cycles", stb_cnt, mon_e.stb_n);
                    chk("busy_done", {31'h0, o_busy}, 32'h0);
                end
                stb_cnt = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {20'h0, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_completed,
                            o_busy, o_fault, o_fault_cause}, 32'h0);
        chk({tag, "_addr"}, o_wb_addr, 32'h0);
        chk({tag, "_data"}, o_wb_data, 32'h0);
        chk({tag, "_rdata"}, o_rdata, 32'h0);
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] width, input logic sgn, input int stall,
                             input int wt, input logic err, input logic ack_too,
                             input logic hang, input logic [31:0] bdata, input logic spam);
        exp_t       e;
        logic [1:0] ln;
        logic [7:0] b;
        logic [15:0] h;
        logic       bad_w, mis;
        ln    = addr[1:0];
        b     = bdata[8*ln +: 8];
        h     = bdata[16*ln[1] +: 16];
        bad_w = (width == 2'b00);
        mis   = ((width == 2'b10) && ln[0]) || ((width == 2'b11) && (ln != 2'b00));
        e.addr = {addr[31:2], 2'b00};
        e.we   = we;
        e.sel  = 4'b0000;
        e.data = wdata;
        case (width)
            2'b01: begin e.sel = 4'b0001 << ln; e.data = {4{wdata[7:0]}}; end
            2'b10: begin e.sel = ln[1] ? 4'b1100 : 4'b0011; e.data = {2{wdata[15:0]}}; end
            2'b11: e.sel = 4'b1111;
            default: e.sel = 4'b0000;
        endcase
        e.cause = 2'b00;
        if (bad_w || mis) begin
            e.fault = 1'b1; e.cause = bad_w ? 2'b00 : 2'b01; e.lat = 1; e.stb_n = 0;
        end else if (hang) begin
`ifdef LSU_WB_TIMEOUT_EN
            e.fault = 1'b1; e.cause = 2'b11; e.lat = 1 + TO; e.stb_n = 1;
`else
            e.fault = 1'b0; e.lat = 0; e.stb_n = 0;
`endif
        end else if (err) begin
            e.fault = 1'b1; e.cause = 2'b10; e.lat = 2 + stall + wt; e.stb_n = stall + 1;
        end else begin
            e.fault = 1'b0; e.lat = 2 + stall + wt; e.stb_n = stall + 1;
            if (!we) begin
                case (width)
                    2'b01:   m_rdata = sgn ? {{24{b[7]}}, b} : {24'h0, b};
                    2'b10:   m_rdata = sgn ? {{16{h[15]}}, h} : {16'h0, h};
                    default: m_rdata = bdata;
                endcase
            end
        end
        e.rdata = m_rdata;
        sl_stall = stall; sl_wait = wt; sl_err = err; sl_ack_too = ack_too;
        sl_hang = hang; sl_data = bdata; sl_cnt = 0; sl_wcnt = 0;
        @(negedge clk);
        i_we = we; i_addr = addr; i_wdata = wdata; i_width = width; i_signed = sgn;
        i_enable = 1'b1;
        e.t_en = cycle_n;
        sb_q.push_back(e);
        @(negedge clk);
        if (!spam) i_enable = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        i_enable = 1'b0;
        chk("drain", sb_q.size(), 0);
        if (sb_q.size() != 0) begin
            reset = 1'b0;
            @(negedge clk);
            sb_q.delete();
            m_rdata = '0;
            reset = 1'b1;
        end
    endtask

    task automatic abort_by_reset(input string tag);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        sb_q.delete();
        m_rdata = '0;
        sl_hang = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; i_enable = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        i_width = 2'b00; i_signed = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // loads: word, signed/unsigned byte, halves, word ignores sign
        start_req(0, 32'hb000_0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 32'hdead_beef, 0); wait_done();
        start_req(0, 32'hb000_0013, 0, 2'b01, 1, 0, 0, 0, 0, 0, 32'h8011_2233, 0); wait_done();
        start_req(0, 32'hb000_0013, 0, 2'b01, 0, 0, 0, 0, 0, 0, 32'h8011_2233, 0); wait_done();
        start_req(0, 32'hb000_0002, 0, 2'b10, 1, 0, 1, 0, 0, 0, 32'h8001_1234, 0); wait_done();
        start_req(0, 32'hb000_0041, 0, 2'b01, 0, 2, 2, 0, 0, 0, 32'h0000_a500, 0); wait_done();
        start_req(0, 32'hb000_0044, 0, 2'b10, 0, 0, 0, 0, 0, 0, 32'h1234_f00d, 0); wait_done();
        start_req(0, 32'hb000_0048, 0, 2'b11, 1, 1, 0, 0, 0, 0, 32'h8000_0001, 0); wait_done();

        // stores: stalled half, byte with wait, word
        start_req(1, 32'hb000_0002, 32'h0000_abcd, 2'b10, 0, 3, 0, 0, 0, 0, 32'h0, 0); wait_done();
        start_req(1, 32'hb000_0051, 32'h1234_565a, 2'b01, 0, 0, 1, 0, 0, 0, 32'h0, 0); wait_done();
        start_req(1, 32'hb000_0054, 32'h1234_5678, 2'b11, 0, 0, 0, 0, 0, 0, 32'h0, 0); wait_done();

        // check faults: misaligned word/half, bad width, then a clean load clears o_fault
        start_req(0, 32'hb000_0006, 0, 2'b11, 0, 0, 0, 0, 0, 0, 32'h0, 0); wait_done();
        start_req(0, 32'hb000_0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0); wait_done();
        start_req(1, 32'hb000_0003, 32'h5555, 2'b10, 0, 0, 0, 0, 0, 0, 32'h0, 0); wait_done();
        start_req(0, 32'hb000_0060, 0, 2'b11, 0, 0, 0, 0, 0, 0, 32'h0bad_cafe, 0); wait_done();

        // bus errors: err with ack in accept cycle, err alone after waits on a store
        start_req(0, 32'hb000_0070, 0, 2'b11, 0, 0, 0, 1, 1, 0, 32'h1111_2222, 0); wait_done();
        start_req(1, 32'hb000_0074, 32'h77, 2'b01, 0, 1, 2, 1, 0, 0, 32'h0, 0); wait_done();
        start_req(0, 32'hb000_0078, 0, 2'b10, 1, 0, 0, 0, 0, 0, 32'h7fff_0000, 0); wait_done();

        // enable held high through busy and DONE must not start another access
        start_req(0, 32'hb000_0080, 0, 2'b11, 0, 2, 1, 0, 0, 0, 32'hc0de_0001, 1); wait_done();
        repeat (3) @(negedge clk);
        chk("no_requeue", {31'h0, o_wb_cyc}, 32'h0);

        // reset while waiting for ack abandons the cycle without completion
        start_req(0, 32'hb000_0090, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        for (int k = 0; k < 20 && !(o_wb_cyc && !o_wb_stb); k++) @(negedge clk);
        chk("in_wait_ack", {30'h0, o_wb_cyc, o_wb_stb}, 32'h2);
        abort_by_reset("rst_abort");

`ifdef LSU_WB_TIMEOUT_EN
        start_req(0, 32'hb000_00a0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'h0, 0); wait_done();
        sl_hang = 1'b0;
`else
        start_req(0, 32'hb000_00a0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        n = 0;
        repeat (120) begin
            if (o_wb_cyc) n++;
            @(negedge clk);
        end
        chk("no_timeout_cyc", n, 120);
        abort_by_reset("rst_hang");
`endif

        start_req(0, 32'hb000_00b2, 0, 2'b10, 1, 0, 0, 0, 0, 0, 32'hfe01_0203, 0); wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
